// File: rtl/pkt_fifo_reader.sv
// Read-side controller for the synchronous packet FIFO: pops elements through a 2-entry skid
// buffer onto a valid/ready sop/eop stream, and rewinds the FIFO read pointer on replay.
module pkt_fifo_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_DATA     = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_ren,
  input  logic [W_DATA+1:0]     fifo_rdata,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rptr,
  output logic                  fifo_rrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_rptr,
  output logic [W_DATA-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  replay,
  output logic                  pkt_done,
  output logic                  frame_err
);

  localparam int SOP = W_DATA;
  localparam int EOP = W_DATA + 1;

  typedef enum logic [1:0] {WAIT, RUN, REWIND, SETTLE} state_t;

  state_t                state;
  logic [W_DATA+1:0]     skid0, skid1;
  logic [1:0]            skid_count;
  logic                  inflight;
  logic [ADDR_WIDTH:0]   ptr_q, start_ptr, pend_ptr;
  logic                  in_pkt, rx_in_pkt, pend_valid;

  logic ret_valid, ret_sop, ret_eop, drop, push, pop;
  logic eop_acc, held_eop, rewind_go, room;

  always_comb begin
    ret_valid = inflight && (state == RUN);
    ret_sop   = fifo_rdata[SOP];
    ret_eop   = fifo_rdata[EOP];
    drop      = ret_valid && !ret_sop && !rx_in_pkt;
    push      = ret_valid && !drop;
    out_valid = (state == RUN) && (skid_count != 2'd0);
    pop       = out_valid && out_ready;
    eop_acc   = pop && skid0[EOP];
    // An eop still waiting in the skid means a returning sop belongs to the next packet.
    held_eop  = ((skid_count != 2'd0) && skid0[EOP] && !pop) ||
                ((skid_count == 2'd2) && skid1[EOP]);
    rewind_go = (state == RUN) && replay && in_pkt && !eop_acc;
    // Credit the beat leaving this cycle so the stream sustains one beat per cycle.
    room      = (({1'b0, skid_count} + {2'b00, inflight}) < 3'd2) || pop;
    fifo_ren  = (state == RUN) && !fifo_empty && room && !rewind_go;
  end

  assign out_data = skid0[W_DATA-1:0];
  assign out_sop  = skid0[SOP];
  assign out_eop  = skid0[EOP];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT;
      skid0         <= '0;
      skid1         <= '0;
      skid_count    <= '0;
      inflight      <= 1'b0;
      ptr_q         <= '0;
      start_ptr     <= '0;
      pend_ptr      <= '0;
      in_pkt        <= 1'b0;
      rx_in_pkt     <= 1'b0;
      pend_valid    <= 1'b0;
      fifo_rrst     <= 1'b0;
      fifo_rst_rptr <= '0;
      pkt_done      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      pkt_done      <= eop_acc;
      fifo_rrst     <= rewind_go;
      fifo_rst_rptr <= rewind_go ? start_ptr : '0;
      if (fifo_ren) ptr_q <= fifo_rptr;

      case (state)
        WAIT:   state <= RUN;
        RUN: begin
          if (rewind_go) begin
            state      <= REWIND;
            skid_count <= '0;
            inflight   <= 1'b0;
            in_pkt     <= 1'b0;
            rx_in_pkt  <= 1'b0;
            pend_valid <= 1'b0;
          end else begin
            inflight <= fifo_ren;
            if (ret_valid && (drop || (ret_sop && rx_in_pkt))) frame_err <= 1'b1;
            if (push) rx_in_pkt <= !ret_eop;

            case ({push, pop})
              2'b10: begin
                if (skid_count == 2'd0) skid0 <= fifo_rdata;
                else                    skid1 <= fifo_rdata;
                skid_count <= skid_count + 2'd1;
              end
              2'b01: begin
                skid0      <= skid1;
                skid_count <= skid_count - 2'd1;
              end
              2'b11: begin
                if (skid_count == 2'd1) skid0 <= fifo_rdata;
                else begin
                  skid0 <= skid1;
                  skid1 <= fifo_rdata;
                end
              end
              default: ;
            endcase

            if (push && ret_sop) begin
              if (held_eop) begin
                pend_valid <= 1'b1;
                pend_ptr   <= ptr_q;
              end else begin
                start_ptr <= ptr_q;
                in_pkt    <= 1'b1;
              end
            end else if (eop_acc) begin
              in_pkt     <= pend_valid;
              pend_valid <= 1'b0;
              if (pend_valid) start_ptr <= pend_ptr;
            end
          end
        end
        REWIND: state <= SETTLE;
        SETTLE: state <= RUN;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Scoreboard bench for pkt_fifo_reader: a behavioural FIFO feeds the reader, directed packets
// are pushed as expected beats, and a negedge monitor pops and compares every accepted beat.
module tb_pkt_fifo_reader;

  localparam int AW = 10;
  localparam int WD = 18;

  logic          clk, reset;
  logic          fifo_ren, fifo_empty, fifo_rrst;
  logic [WD+1:0] fifo_rdata;
  logic [AW:0]   fifo_rptr, fifo_rst_rptr;
  logic [WD-1:0] out_data;
  logic          out_sop, out_eop, out_valid, out_ready, replay;
  logic          pkt_done, frame_err;

  pkt_fifo_reader #(.ADDR_WIDTH(AW), .W_DATA(WD)) dut (
    .clk(clk), .reset(reset),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_rptr(fifo_rptr), .fifo_rrst(fifo_rrst), .fifo_rst_rptr(fifo_rst_rptr),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid),
    .out_ready(out_ready), .replay(replay), .pkt_done(pkt_done), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, pointer load for test setup, rrst rewind.
  logic [WD+1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   m_rptr, m_wptr, load_ptr;
  logic          load;

  assign fifo_empty = (m_rptr == m_wptr);
  assign fifo_rptr  = m_rptr;

  always_ff @(posedge clk) begin
    if (load) begin
      m_rptr     <= load_ptr;
      fifo_rdata <= '0;
    end else if (fifo_rrst) begin
      m_rptr <= fifo_rst_rptr;
    end else if (fifo_ren) begin
      fifo_rdata <= mem[m_rptr[AW-1:0]];
      m_rptr     <= m_rptr + 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic [WD+1:0] exp_q [$];

  // Monitor state
  logic          stall_pend = 1'b0;
  logic [WD+1:0] held = '0;
  int            done_cnt = 0, rrst_cnt = 0, overlap_cnt = 0;
  int            iss = 0, acc = 0, max_out = 0;
  logic [AW:0]   rrst_ptr_seen = '0;
  logic          mon_out_en = 1'b1;

  always @(negedge clk) begin
    int cur;
    if (reset) begin
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_eop, out_sop, out_data}, held);
      end
      stall_pend <= out_valid && !out_ready && !replay;
      held       <= {out_eop, out_sop, out_data};

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got %0h expected none", {out_eop, out_sop, out_data});
        end else begin
          check("beat", {out_eop, out_sop, out_data}, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end

      if (pkt_done) done_cnt <= done_cnt + 1;
      if (fifo_rrst) begin
        rrst_cnt      <= rrst_cnt + 1;
        rrst_ptr_seen <= fifo_rst_rptr;
      end
      if (fifo_ren && fifo_rrst) overlap_cnt <= overlap_cnt + 1;

      if (mon_out_en) begin
        cur = (iss + int'(fifo_ren)) - (acc + int'(out_valid && out_ready));
        iss <= iss + int'(fifo_ren);
        acc <= acc + int'(out_valid && out_ready);
        if (cur > max_out) max_out <= cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_pkt(input logic [AW:0] base, input int n, input logic [WD-1:0] d0);
    logic [AW:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + (AW+1)'(i);
      mem[a[AW-1:0]] = {(i == n-1), (i == 0), d0 + WD'(i)};
    end
  endtask

  task automatic exp_beats(input int n, input logic [WD-1:0] d0, input int from, input int upto);
    for (int i = from; i <= upto; i++)
      exp_q.push_back({(i == n-1), (i == 0), d0 + WD'(i)});
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {fifo_ren, fifo_rrst, out_valid, out_sop, out_eop, out_data,
                 pkt_done, frame_err, fifo_rst_rptr}, 0);
  endtask

  task automatic do_reset(input logic [AW:0] start);
    reset     = 1'b1;
    replay    = 1'b0;
    out_ready = 1'b1;
    load_ptr  = start;
    load      = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check_outputs_zero("reset_outputs");
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_accept(input string name, input logic [WD-1:0] d, input logic need_eop);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_data == d && (!need_eop || out_eop)) found = 1'b1;
    end
    check(name, found, 1);
  endtask

  initial begin
    int base_done, base_rrst;
    logic [3:0] pat;
    logic found;
    reset = 1'b1; out_ready = 1'b0; replay = 1'b0; load = 1'b0;
    load_ptr = '0; m_wptr = '0;

    // 1: preloaded 4-beat packet, out_ready=1
    do_reset(11'h000);
    put_pkt(11'h000, 4, 18'h10001);
    m_wptr = 11'h004;
    exp_beats(4, 18'h10001, 0, 3);
    base_done = done_cnt;
    reset = 1'b0;
    @(negedge clk); check("wait_ren", fifo_ren, 0);
    @(negedge clk); check("run_ren", fifo_ren, 1);
    @(negedge clk); check("latency_early", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("b2b_valid", out_valid, 1);
    end
    tick();
    drain("t1_drain");
    check("t1_done", done_cnt - base_done, 1);

    // 2: same packet shape, out_ready toggling 1,0,0,1
    put_pkt(11'h004, 4, 18'h20001);
    exp_beats(4, 18'h20001, 0, 3);
    base_done = done_cnt;
    pat = 4'b1001;
    m_wptr = 11'h008;
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
      out_ready = pat[k % 4];
      tick();
    end
    out_ready = 1'b1;
    drain("t2_drain");
    check("t2_done", done_cnt - base_done, 1);
    check("t2_outstanding", (max_out <= 2), 1);
    mon_out_en = 1'b0;

    // 3: packet across the pointer wrap, replay after beat2 accepted
    do_reset(11'h7FE);
    put_pkt(11'h7FE, 4, 18'h30001);
    m_wptr = 11'h002;
    exp_beats(4, 18'h30001, 0, 2);
    base_done = done_cnt; base_rrst = rrst_cnt;
    reset = 1'b0;
    wait_accept("t3_beat2", 18'h30003, 1'b0);
    tick();
    out_ready = 1'b0; replay = 1'b1;
    exp_beats(4, 18'h30001, 0, 3);
    tick();
    replay = 1'b0; out_ready = 1'b1;
    drain("t3_drain");
    check("t3_rrst_cnt", rrst_cnt - base_rrst, 1);
    check("t3_rst_rptr", rrst_ptr_seen, 11'h7FE);
    check("t3_done", done_cnt - base_done, 1);

    // 4: replay in the cycle the eop beat is accepted is ignored
    do_reset(11'h000);
    put_pkt(11'h000, 3, 18'h40001);
    put_pkt(11'h003, 2, 18'h50001);
    m_wptr = 11'h005;
    exp_beats(3, 18'h40001, 0, 2);
    exp_beats(2, 18'h50001, 0, 1);
    base_done = done_cnt; base_rrst = rrst_cnt;
    reset = 1'b0;
    wait_accept("t4_eop", 18'h40003, 1'b1);
    replay = 1'b1;
    tick();
    replay = 1'b0;
    drain("t4_drain");
    check("t4_no_rrst", rrst_cnt - base_rrst, 0);
    check("t4_done", done_cnt - base_done, 2);

    // 5: orphan beat before any sop is dropped and flags frame_err
    do_reset(11'h000);
    mem[0] = {1'b0, 1'b0, 18'h3ABCD};
    put_pkt(11'h001, 3, 18'h70001);
    m_wptr = 11'h004;
    exp_beats(3, 18'h70001, 0, 2);
    base_done = done_cnt;
    reset = 1'b0;
    drain("t5_drain");
    check("t5_frame_err", frame_err, 1);
    check("t5_done", done_cnt - base_done, 1);

    // 6: reset asserted during SETTLE
    do_reset(11'h100);
    put_pkt(11'h100, 4, 18'h80001);
    m_wptr = 11'h104;
    exp_beats(4, 18'h80001, 0, 1);
    base_done = done_cnt; base_rrst = rrst_cnt;
    reset = 1'b0;
    wait_accept("t6_beat1", 18'h80002, 1'b0);
    tick();
    out_ready = 1'b0; replay = 1'b1;
    exp_beats(4, 18'h80001, 0, 3);
    tick();
    replay = 1'b0; out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fifo_rrst) found = 1'b1;
    end
    check("t6_rrst_seen", found, 1);
    tick();
    reset = 1'b1;
    tick();
    check_outputs_zero("t6_reset_outputs");
    reset = 1'b0;
    @(negedge clk); check("t6_wait_ren", fifo_ren, 0);
    @(negedge clk); check("t6_resume_ren", fifo_ren, 1);
    drain("t6_drain");
    check("t6_rrst_cnt", rrst_cnt - base_rrst, 1);
    check("t6_rst_rptr", rrst_ptr_seen, 11'h100);
    check("t6_done", done_cnt - base_done, 1);

    check("ren_rrst_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
